// File: rtl/utils_pkg.sv
`default_nettype none
// utils_pkg: AXI4 channel types, FSM state encodings and burst helpers
// shared by the on-chip memory responder.
package utils_pkg;

  localparam int unsigned ID_W = 4;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} axi_burst_t;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} axi_resp_t;

  typedef struct packed {
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    axi_burst_t      awburst;
    logic            awvalid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            bready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    axi_burst_t      arburst;
    logic            arvalid;
    logic            rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic            awready;
    logic            wready;
    logic [ID_W-1:0] bid;
    axi_resp_t       bresp;
    logic            bvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    axi_resp_t       rresp;
    logic            rlast;
    logic            rvalid;
  } s_axi_miso_t;

  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_BURST = 1'b1} rd_fsm_t;
  typedef enum logic [1:0] {WR_IDLE = 2'b00, WR_DATA = 2'b01, WR_RESP = 2'b10} wr_fsm_t;

  // Only FIXED and INCR bursts of at most one data-bus width are served.
  function automatic logic burst_legal(input logic [2:0] size, input axi_burst_t burst);
    return (size <= 3'd2) && ((burst == FIXED) || (burst == INCR));
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input axi_burst_t burst);
    return (burst == INCR) ? a + (32'd1 << size) : a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_dp_be.sv
`default_nettype none
// ram_dp_be: one synchronous read-first read port plus one byte-enabled
// write port over a 32-bit word array; contents are never reset.
module ram_dp_be #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Read data only reloads on re_i, so it stays put while the consumer stalls.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_mem_slave.sv
`default_nettype none
// axi_mem_slave: AXI4 responder over an on-chip RAM window with independent
// read and write channel FSMs, byte strobes and DECERR/SLVERR reporting.
module axi_mem_slave
  import utils_pkg::*;
#(
  parameter int unsigned MEM_KB    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        arst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int unsigned DEPTH     = MEM_KB * 256;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_KB * 1024);

  // Modulo-2^32 offset makes addresses below BASE_ADDR fall out of range too.
  function automatic logic in_window(input logic [31:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  rd_fsm_t         rd_state_q, rd_state_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     raddr_q, raddr_d;
  logic [7:0]      rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]      rsize_q, rsize_d;
  axi_burst_t      rburst_q, rburst_d;

  wr_fsm_t         wr_state_q, wr_state_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [7:0]      wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]      wsize_q, wsize_d;
  axi_burst_t      wburst_q, wburst_d;
  logic            wover_q, wover_d, wdec_q, wdec_d;
  axi_resp_t       bresp_q, bresp_d;

  logic        ram_re, ram_we;
  logic [31:0] ram_raddr, ram_rdata;
  axi_resp_t   rresp;
  logic        w_in_win, w_legal;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rd_state_q <= RD_IDLE;
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rbeat_q    <= '0;
      rsize_q    <= '0;
      rburst_q   <= INCR;
      wr_state_q <= WR_IDLE;
      bid_q      <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wbeat_q    <= '0;
      wsize_q    <= '0;
      wburst_q   <= INCR;
      wover_q    <= 1'b0;
      wdec_q     <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rbeat_q    <= rbeat_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      wr_state_q <= wr_state_d;
      bid_q      <= bid_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wbeat_q    <= wbeat_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wover_q    <= wover_d;
      wdec_q     <= wdec_d;
      bresp_q    <= bresp_d;
    end
  end

  // The RAM is read at the address of the beat about to be presented, so its
  // registered output lines up with rvalid one cycle later.
  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rbeat_d    = rbeat_q;
    rsize_d    = rsize_q;
    rburst_d   = rburst_q;
    ram_re     = 1'b0;
    ram_raddr  = raddr_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (axi_mosi_i.arvalid) begin
          rid_d      = axi_mosi_i.arid;
          raddr_d    = axi_mosi_i.araddr;
          rlen_d     = axi_mosi_i.arlen;
          rsize_d    = axi_mosi_i.arsize;
          rburst_d   = axi_mosi_i.arburst;
          rbeat_d    = '0;
          ram_re     = 1'b1;
          ram_raddr  = axi_mosi_i.araddr;
          rd_state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (axi_mosi_i.rready) begin
          if (rbeat_q == rlen_q) begin
            rd_state_d = RD_IDLE;
          end else begin
            rbeat_d   = rbeat_q + 8'd1;
            raddr_d   = next_addr(raddr_q, rsize_q, rburst_q);
            ram_re    = 1'b1;
            ram_raddr = raddr_d;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign rresp    = !burst_legal(rsize_q, rburst_q) ? SLVERR :
                    !in_window(raddr_q)             ? DECERR : OKAY;
  assign w_in_win = in_window(waddr_q);
  assign w_legal  = burst_legal(wsize_q, wburst_q);

  always_comb begin
    wr_state_d = wr_state_q;
    bid_d      = bid_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wbeat_d    = wbeat_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wover_d    = wover_q;
    wdec_d     = wdec_q;
    bresp_d    = bresp_q;
    ram_we     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (axi_mosi_i.awvalid) begin
          bid_d      = axi_mosi_i.awid;
          waddr_d    = axi_mosi_i.awaddr;
          wlen_d     = axi_mosi_i.awlen;
          wsize_d    = axi_mosi_i.awsize;
          wburst_d   = axi_mosi_i.awburst;
          wbeat_d    = '0;
          wover_d    = 1'b0;
          wdec_d     = 1'b0;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (axi_mosi_i.wvalid) begin
          ram_we  = !wover_q && w_in_win && w_legal;
          wdec_d  = wdec_q || !w_in_win;
          waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
          // wover marks that awlen+1 beats have been seen; the counter stops there.
          if (wbeat_q == wlen_q) wover_d = 1'b1;
          else                   wbeat_d = wbeat_q + 8'd1;
          if (axi_mosi_i.wlast) begin
            wr_state_d = WR_RESP;
            bresp_d    = wdec_d                                        ? DECERR :
                         (!w_legal || wover_q || (wbeat_q != wlen_q)) ? SLVERR : OKAY;
          end
        end
      end
      WR_RESP: begin
        if (axi_mosi_i.bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  ram_dp_be #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .re_i    (ram_re),
    .raddr_i (word_idx(ram_raddr)),
    .rdata_o (ram_rdata),
    .we_i    (ram_we),
    .be_i    (axi_mosi_i.wstrb),
    .waddr_i (word_idx(waddr_q)),
    .wdata_i (axi_mosi_i.wdata)
  );

  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.arready = (rd_state_q == RD_IDLE);
    axi_miso_o.rvalid  = (rd_state_q == RD_BURST);
    axi_miso_o.rid     = rid_q;
    if (rd_state_q == RD_BURST) begin
      axi_miso_o.rlast = (rbeat_q == rlen_q);
      axi_miso_o.rresp = rresp;
      axi_miso_o.rdata = (rresp == OKAY) ? ram_rdata : 32'h0;
    end
    axi_miso_o.awready = (wr_state_q == WR_IDLE);
    axi_miso_o.wready  = (wr_state_q == WR_DATA);
    axi_miso_o.bvalid  = (wr_state_q == WR_RESP);
    axi_miso_o.bid     = bid_q;
    axi_miso_o.bresp   = (wr_state_q == WR_RESP) ? bresp_q : OKAY;
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// tb_axi_mem_slave: directed AXI traffic with queued expectations checked by
// an independent R/B channel monitor.
module tb_axi_mem_slave;
  import utils_pkg::*;

  localparam int unsigned MEM_KB = 4;
  localparam logic [31:0] BASE   = 32'h1000_0000;

  logic        clk  = 1'b0;
  logic        arst = 1'b0;
  logic        rr   = 1'b1;
  logic        toggle_rr = 1'b0;
  s_axi_mosi_t m;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  always #5 clk = ~clk;

  always_comb begin
    mosi        = m;
    mosi.rready = rr;
  end

  always @(posedge clk) begin
    #1;
    rr = toggle_rr ? ~rr : 1'b1;
  end

  axi_mem_slave #(.MEM_KB(MEM_KB), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .arst       (arst),
    .axi_mosi_i (mosi),
    .axi_miso_o (miso)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    axi_resp_t       resp;
    logic            last;
  } r_exp_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    axi_resp_t       resp;
  } b_exp_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];
  int errors = 0;
  int checks = 0;
  int r_pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout, got no handshake expected one within 200 cycles", name);
  endtask

  r_exp_t re, held;
  b_exp_t be;
  logic   have_held = 1'b0;

  always @(negedge clk) begin
    if (!arst) begin
      have_held = 1'b0;
    end else begin
      if (miso.rvalid) begin
        if (have_held) begin
          check("r_stall_data", miso.rdata, held.data);
          check("r_stall_resp", 32'(miso.rresp), 32'(held.resp));
          check("r_stall_last", 32'(miso.rlast), 32'(held.last));
        end
        if (mosi.rready) begin
          if (r_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL r_unexpected: got beat %h expected no beat", miso.rdata);
          end else begin
            re = r_q.pop_front();
            check("r_id", 32'(miso.rid), 32'(re.id));
            check("r_data", miso.rdata, re.data);
            check("r_resp", 32'(miso.rresp), 32'(re.resp));
            check("r_last", 32'(miso.rlast), 32'(re.last));
            r_pops++;
          end
          have_held = 1'b0;
        end else begin
          held      = '{id: miso.rid, data: miso.rdata, resp: miso.rresp, last: miso.rlast};
          have_held = 1'b1;
        end
      end else begin
        have_held = 1'b0;
      end
      if (miso.bvalid && mosi.bready) begin
        if (b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: got bresp %0d expected no response", miso.bresp);
        end else begin
          be = b_q.pop_front();
          check("b_id", 32'(miso.bid), 32'(be.id));
          check("b_resp", 32'(miso.bresp), 32'(be.resp));
        end
      end
    end
  end

  // which: 0 = AW, 1 = W, 2 = AR
  task automatic wait_hs(input string name, input int which);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((which == 0 && miso.awready) || (which == 1 && miso.wready) ||
          (which == 2 && miso.arready)) break;
      n++;
      if (n > 200) begin
        tmo(name);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input axi_burst_t burst, input int nb, input logic [31:0] d0,
                          input logic [31:0] step, input logic [3:0] strb, input axi_resp_t resp);
    b_q.push_back('{id: id, resp: resp});
    m.awid = id; m.awaddr = addr; m.awlen = len; m.awsize = 3'd2; m.awburst = burst;
    m.awvalid = 1'b1;
    wait_hs("aw_handshake", 0);
    m.awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      m.wdata  = d0 + step * 32'(i);
      m.wstrb  = strb;
      m.wlast  = (i == nb - 1);
      m.wvalid = 1'b1;
      wait_hs("w_handshake", 1);
    end
    m.wvalid = 1'b0;
    m.wlast  = 1'b0;
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input axi_burst_t burst);
    m.arid = id; m.araddr = addr; m.arlen = len; m.arsize = 3'd2; m.arburst = burst;
    m.arvalid = 1'b1;
    wait_hs("ar_handshake", 2);
    m.arvalid = 1'b0;
  endtask

  task automatic push_r(input logic [ID_W-1:0] id, input logic [31:0] data, input axi_resp_t resp,
                        input logic last);
    r_q.push_back('{id: id, data: data, resp: resp, last: last});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (r_q.size() != 0 || b_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        tmo(name);
        r_q.delete();
        b_q.delete();
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  int base_pops;
  int nwait;

  initial begin
    m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(miso.arready), 32'd1);
    check("rst_awready", 32'(miso.awready), 32'd1);
    check("rst_wready",  32'(miso.wready),  32'd0);
    check("rst_rvalid",  32'(miso.rvalid),  32'd0);
    check("rst_bvalid",  32'(miso.bvalid),  32'd0);
    check("rst_rlast",   32'(miso.rlast),   32'd0);
    check("rst_rresp",   32'(miso.rresp),   32'(OKAY));
    check("rst_bresp",   32'(miso.bresp),   32'(OKAY));
    check("rst_ids",     32'({miso.rid, miso.bid}), 32'd0);
    @(posedge clk);
    #1;
    arst     = 1'b1;
    m.bready = 1'b1;

    // single full-word write, read back
    do_write(4'd3, BASE + 32'h10, 8'd0, INCR, 1, 32'hDEADBEEF, 32'h0, 4'hF, OKAY);
    push_r(4'd5, 32'hDEADBEEF, OKAY, 1'b1);
    do_read(4'd5, BASE + 32'h10, 8'd0, INCR);
    wait_drain("drain_single");

    // low-half strobe merge
    do_write(4'd6, BASE + 32'h10, 8'd0, INCR, 1, 32'h0000AAAA, 32'h0, 4'h3, OKAY);
    push_r(4'd7, 32'hDEADAAAA, OKAY, 1'b1);
    do_read(4'd7, BASE + 32'h10, 8'd0, INCR);
    wait_drain("drain_strobe");

    // 4-beat INCR, read back with rready toggling
    do_write(4'd1, BASE, 8'd3, INCR, 4, 32'h11111111, 32'h11111111, 4'hF, OKAY);
    toggle_rr = 1'b1;
    for (int i = 0; i < 4; i++) push_r(4'd2, 32'h11111111 * 32'(i + 1), OKAY, i == 3);
    do_read(4'd2, BASE, 8'd3, INCR);
    wait_drain("drain_incr_stall");
    toggle_rr = 1'b0;

    // top of window: second beat falls outside
    do_write(4'd4, BASE + 32'hFFC, 8'd0, INCR, 1, 32'hCAFEF00D, 32'h0, 4'hF, OKAY);
    push_r(4'd8, 32'hCAFEF00D, OKAY, 1'b0);
    push_r(4'd8, 32'h0, DECERR, 1'b1);
    do_read(4'd8, BASE + 32'hFFC, 8'd1, INCR);
    wait_drain("drain_edge");
    do_write(4'd9, BASE + 32'h1000, 8'd0, INCR, 1, 32'h12345678, 32'h0, 4'hF, DECERR);
    wait_drain("drain_oow_write");

    // early wlast, then WRAP read
    do_write(4'd2, BASE + 32'h24, 8'd0, INCR, 1, 32'h0, 32'h0, 4'hF, OKAY);
    do_write(4'd3, BASE + 32'h20, 8'd1, INCR, 1, 32'h55555555, 32'h0, 4'hF, SLVERR);
    push_r(4'd4, 32'h55555555, OKAY, 1'b0);
    push_r(4'd4, 32'h0, OKAY, 1'b1);
    do_read(4'd4, BASE + 32'h20, 8'd1, INCR);
    wait_drain("drain_short");
    push_r(4'd6, 32'h0, SLVERR, 1'b0);
    push_r(4'd6, 32'h0, SLVERR, 1'b1);
    do_read(4'd6, BASE, 8'd1, WRAP);
    wait_drain("drain_wrap");

    // concurrent 8-beat write and read on disjoint ranges
    do_write(4'd5, BASE + 32'h200, 8'd7, INCR, 8, 32'hB0000000, 32'h1, 4'hF, OKAY);
    wait_drain("drain_prefill");
    for (int i = 0; i < 8; i++) push_r(4'd1, 32'hB0000000 + 32'(i), OKAY, i == 7);
    fork
      do_write(4'd7, BASE + 32'h100, 8'd7, INCR, 8, 32'hA0000000, 32'h1, 4'hF, OKAY);
      do_read(4'd1, BASE + 32'h200, 8'd7, INCR);
    join
    wait_drain("drain_concurrent");

    // reset in the middle of a read burst
    for (int i = 0; i < 8; i++) push_r(4'd3, 32'hA0000000 + 32'(i), OKAY, i == 7);
    base_pops = r_pops;
    do_read(4'd3, BASE + 32'h100, 8'd7, INCR);
    nwait = 0;
    while (r_pops < base_pops + 3 && nwait < 200) begin
      @(posedge clk);
      #1;
      nwait++;
    end
    if (nwait >= 200) tmo("mid_read_beats");
    arst = 1'b0;
    r_q.delete();
    @(negedge clk);
    check("midrst_rvalid",  32'(miso.rvalid),  32'd0);
    check("midrst_arready", 32'(miso.arready), 32'd1);
    check("midrst_rlast",   32'(miso.rlast),   32'd0);
    @(posedge clk);
    #1;
    arst = 1'b1;
    push_r(4'd4, 32'hA0000000, OKAY, 1'b0);
    push_r(4'd4, 32'hA0000001, OKAY, 1'b1);
    do_read(4'd4, BASE + 32'h100, 8'd1, INCR);
    wait_drain("drain_after_reset");

    check("queues_empty", 32'(r_q.size() + b_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
